// File: rtl/ystep_ctrl.sv
// ystep_ctrl: multi-cycle sequencer driving yIF/yID/yEX control and owning PC.
// Define YSTEP_BRANCH_EN to decode beq; otherwise opcode 0x04 is illegal.
module ystep_ctrl #(
  parameter logic [31:0] RESET_PC = 32'd128,
  parameter logic [15:0] MAX_INS  = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] ins,
  input  logic [31:0] PCp4,
  input  logic [31:0] imm,
  input  logic [25:0] jTarget,
  input  logic        zero,
  output logic [31:0] PCin,
  output logic        fetch_en,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        Mem2Reg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  op,
  output logic        retire,
  output logic [15:0] ins_count,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DEC, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  opc_q, fn_q;
  logic        ill_q, ill_d;

  logic        is_lw, is_sw, is_beq, is_j, legal;
  logic        rd, asrc, m2r;
  logic [2:0]  aop;
  logic [31:0] jpc, pc_nxt;
  logic        active, ret;
  logic        unused_ins;

  assign unused_ins = ^ins[25:6];

  always_comb begin
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    is_beq = 1'b0;
    is_j   = 1'b0;
    legal  = 1'b0;
    rd     = 1'b0;
    asrc   = 1'b0;
    m2r    = 1'b0;
    aop    = 3'd0;
    unique case (1'b1)
      (opc_q == 6'h00): begin
        rd    = 1'b1;
        legal = 1'b1;
        unique case (fn_q)
          6'h20:   aop = 3'd2;
          6'h22:   aop = 3'd6;
          6'h24:   aop = 3'd0;
          6'h25:   aop = 3'd1;
          6'h2A:   aop = 3'd7;
          default: legal = 1'b0;
        endcase
      end
      (opc_q == 6'h08): begin
        asrc  = 1'b1;
        aop   = 3'd2;
        legal = 1'b1;
      end
      (opc_q == 6'h23): begin
        is_lw = 1'b1;
        asrc  = 1'b1;
        m2r   = 1'b1;
        aop   = 3'd2;
        legal = 1'b1;
      end
      (opc_q == 6'h2B): begin
        is_sw = 1'b1;
        asrc  = 1'b1;
        aop   = 3'd2;
        legal = 1'b1;
      end
`ifdef YSTEP_BRANCH_EN
      (opc_q == 6'h04): begin
        is_beq = 1'b1;
        aop    = 3'd6;
        legal  = 1'b1;
      end
`endif
      (opc_q == 6'h02): begin
        is_j  = 1'b1;
        legal = 1'b1;
      end
      default: ;
    endcase
  end

  assign jpc = {PCp4[31:28], jTarget, 2'b00};

`ifdef YSTEP_BRANCH_EN
  assign pc_nxt = is_j ? jpc :
                  (is_beq && zero) ? PCp4 + (imm << 2) :
                  PCp4;
`else
  logic unused_br;
  assign unused_br = ^{imm, zero};
  assign pc_nxt = is_j ? jpc : PCp4;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    ret     = 1'b0;
    unique case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: state_d = S_DEC;
      S_DEC: begin
        if (!legal) begin
          state_d = S_HALT;
          ill_d   = 1'b1;
        end else if (is_j) begin
          ret = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_lw || is_sw) state_d = S_MEM;
        else if (is_beq)    ret = 1'b1;
        else                state_d = S_WB;
      end
      S_MEM: begin
        if (is_lw) state_d = S_WB;
        else       ret = 1'b1;
      end
      S_WB:    ret = 1'b1;
      S_HALT:  ;
      default: state_d = S_IDLE;
    endcase
    if (ret) begin
      pc_d  = pc_nxt;
      cnt_d = cnt_q + 16'd1;
      if (MAX_INS != 16'd0 && cnt_d == MAX_INS) state_d = S_HALT;
      else if (run)                              state_d = S_FETCH;
      else                                       state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      opc_q   <= '0;
      fn_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      if (state_q == S_FETCH) begin
        opc_q <= ins[31:26];
        fn_q  <= ins[5:0];
      end
    end
  end

  // Selects follow the latched instruction only while one is in flight.
  assign active    = (state_q == S_DEC) || (state_q == S_EXEC) ||
                     (state_q == S_MEM) || (state_q == S_WB);
  assign RegDst    = active & rd;
  assign ALUSrc    = active & asrc;
  assign Mem2Reg   = active & m2r;
  assign op        = active ? aop : 3'd0;
  assign RegWrite  = (state_q == S_WB);
  assign MemRead   = (state_q == S_MEM) & is_lw;
  assign MemWrite  = (state_q == S_MEM) & is_sw;
  assign fetch_en  = (state_q == S_FETCH);
  assign retire    = ret;
  assign PCin      = pc_q;
  assign ins_count = cnt_q;
  assign halted    = (state_q == S_HALT);
  assign illegal   = ill_q;

endmodule
